// File: rtl/broadcast_framer.sv
// Serial frame receiver feeding a port/line broadcaster: start, port, line, length, payload.
// Define BCAST_PARITY_EN to add a trailing even-parity bit and the frameErr pulse.
module broadcast_framer (
  input  logic       clk,
  input  logic       rst,
  input  logic       serRx,
  output logic       serIn,
  output logic [3:0] PB,
  output logic [0:1] LB0,
  output logic [0:1] LB1,
  output logic [0:1] LB2,
  output logic [0:1] LB3,
  output logic       busy,
  output logic       frameErr
);

`ifdef BCAST_PARITY_EN
  typedef enum logic [2:0] {IDLE, PORT, LINE, LEN, DATA, PAR} state_t;
`else
  typedef enum logic [2:0] {IDLE, PORT, LINE, LEN, DATA} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  bitCnt_q, bitCnt_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  port_q, port_d;
  logic [1:0]  line_q, line_d;
  logic [2:0]  len_q, len_d;
  logic        serIn_q, serIn_d;
  logic [3:0]  pb_q, pb_d;
  logic        busy_q, busy_d;
  logic [1:0]  lb_q [4];
  logic [1:0]  lb_d [4];
  logic [3:0]  lenVal;
`ifdef BCAST_PARITY_EN
  logic        parity_q, parity_d;
  logic        frameErr_q, frameErr_d;
`endif

  // The full length field is only complete on the edge sampling its last bit.
  assign lenVal = {len_q, serRx};

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    line_d   = line_q;
    len_d    = len_q;
    lb_d     = lb_q;
    serIn_d  = 1'b0;
    pb_d     = 4'b0000;
`ifdef BCAST_PARITY_EN
    parity_d   = parity_q;
    frameErr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!serRx) begin
          state_d  = PORT;
          bitCnt_d = 2'd0;
`ifdef BCAST_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end
      PORT: begin
        port_d = {port_q[0], serRx};
        if (bitCnt_q == 2'd1) begin
          bitCnt_d = 2'd0;
          state_d  = LINE;
        end else begin
          bitCnt_d = bitCnt_q + 2'd1;
        end
      end
      LINE: begin
        line_d = {line_q[0], serRx};
        if (bitCnt_q == 2'd1) begin
          bitCnt_d = 2'd0;
          state_d  = LEN;
        end else begin
          bitCnt_d = bitCnt_q + 2'd1;
        end
      end
      LEN: begin
        len_d = {len_q[1:0], serRx};
        if (bitCnt_q == 2'd3) begin
          // A zero length field encodes the maximum payload of 16 bits.
          cnt_d        = (lenVal == 4'd0) ? 5'd16 : {1'b0, lenVal};
          lb_d[port_q] = line_q;
          bitCnt_d     = 2'd0;
          state_d      = DATA;
        end else begin
          bitCnt_d = bitCnt_q + 2'd1;
        end
      end
      DATA: begin
        serIn_d = serRx;
        pb_d    = 4'b0001 << port_q;
        cnt_d   = cnt_q - 5'd1;
`ifdef BCAST_PARITY_EN
        parity_d = parity_q ^ serRx;
        if (cnt_q == 5'd1) state_d = PAR;
`else
        if (cnt_q == 5'd1) state_d = IDLE;
`endif
      end
`ifdef BCAST_PARITY_EN
      PAR: begin
        frameErr_d = parity_q ^ serRx;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitCnt_q <= 2'd0;
      cnt_q    <= 5'd0;
      port_q   <= 2'd0;
      line_q   <= 2'd0;
      len_q    <= 3'd0;
      serIn_q  <= 1'b0;
      pb_q     <= 4'b0000;
      busy_q   <= 1'b0;
      lb_q     <= '{default: 2'b00};
`ifdef BCAST_PARITY_EN
      parity_q   <= 1'b0;
      frameErr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      line_q   <= line_d;
      len_q    <= len_d;
      serIn_q  <= serIn_d;
      pb_q     <= pb_d;
      busy_q   <= busy_d;
      lb_q     <= lb_d;
`ifdef BCAST_PARITY_EN
      parity_q   <= parity_d;
      frameErr_q <= frameErr_d;
`endif
    end
  end

  // lb_q holds {first, second} line bit, so the first bit lands in LBx[0].
  assign LB0   = lb_q[0];
  assign LB1   = lb_q[1];
  assign LB2   = lb_q[2];
  assign LB3   = lb_q[3];
  assign serIn = serIn_q;
  assign PB    = pb_q;
  assign busy  = busy_q;
`ifdef BCAST_PARITY_EN
  assign frameErr = frameErr_q;
`else
  assign frameErr = 1'b0;
`endif

endmodule

// File: tb/tb_broadcast_framer.sv
// Bench for broadcast_framer: frames are expanded into a per-cycle expectation queue
// from the frame format rules, then driven and compared cycle by cycle.
module tb_broadcast_framer;

  typedef struct {
    logic       rx;
    logic       serIn;
    logic [3:0] pb;
    logic       busy;
    logic       err;
    logic [7:0] lb;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       serRx;
  logic       serIn;
  logic [3:0] PB;
  logic [0:1] LB0, LB1, LB2, LB3;
  logic       busy;
  logic       frameErr;

  int totalChecks = 0;
  int badChecks   = 0;
  logic [1:0] lbModel [4];
  cyc_t q[$];

  broadcast_framer dut (
    .clk(clk), .rst(rst), .serRx(serRx), .serIn(serIn), .PB(PB),
    .LB0(LB0), .LB1(LB1), .LB2(LB2), .LB3(LB3), .busy(busy), .frameErr(frameErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lbPacked();
    return {lbModel[0], lbModel[1], lbModel[2], lbModel[3]};
  endfunction

  function automatic logic payloadXor(input logic [15:0] pl, input int n);
    logic x;
    x = 1'b0;
    for (int i = 0; i < n; i++) x = x ^ pl[i];
    return x;
  endfunction

  task automatic pushCyc(input logic rx, input logic si, input logic [3:0] pb,
                         input logic bz, input logic er);
    cyc_t c;
    c.rx = rx; c.serIn = si; c.pb = pb; c.busy = bz; c.err = er; c.lb = lbPacked();
    q.push_back(c);
  endtask

  task automatic addIdle(input int n);
    repeat (n) pushCyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  // Payload bit i is sent i-th; parBit is only transmitted when parity is enabled.
  task automatic addFrame(input logic [1:0] port, input logic [1:0] line, input logic [3:0] len,
                          input logic [15:0] payload, input logic parBit);
    int n;
    logic [7:0] hdr;
    logic lastBusy;
    n = (len == 4'd0) ? 16 : int'(len);
    hdr = {port, line, len};
`ifdef BCAST_PARITY_EN
    lastBusy = 1'b1;
`else
    lastBusy = 1'b0;
`endif
    pushCyc(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) lbModel[port] = line;
      pushCyc(hdr[i], 1'b0, 4'b0000, 1'b1, 1'b0);
    end
    for (int i = 0; i < n; i++)
      pushCyc(payload[i], payload[i], 4'b0001 << port, (i < n - 1) ? 1'b1 : lastBusy, 1'b0);
`ifdef BCAST_PARITY_EN
    pushCyc(parBit, 1'b0, 4'b0000, 1'b0, payloadXor(payload, n) ^ parBit);
`endif
  endtask

  task automatic applyStimulus(input int limit);
    cyc_t c;
    int k;
    k = 0;
    while (q.size() > 0 && k < limit) begin
      c = q.pop_front();
      serRx = c.rx;
      @(posedge clk);
      @(negedge clk);
      checkOutput("serIn", {15'd0, serIn}, {15'd0, c.serIn});
      checkOutput("PB", {12'd0, PB}, {12'd0, c.pb});
      checkOutput("busy", {15'd0, busy}, {15'd0, c.busy});
      checkOutput("frameErr", {15'd0, frameErr}, {15'd0, c.err});
      checkOutput("LB", {8'd0, LB0, LB1, LB2, LB3}, {8'd0, c.lb});
      k++;
    end
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, "_serIn"}, {15'd0, serIn}, 16'd0);
    checkOutput({tag, "_PB"}, {12'd0, PB}, 16'd0);
    checkOutput({tag, "_busy"}, {15'd0, busy}, 16'd0);
    checkOutput({tag, "_frameErr"}, {15'd0, frameErr}, 16'd0);
    checkOutput({tag, "_LB"}, {8'd0, LB0, LB1, LB2, LB3}, 16'd0);
  endtask

  initial begin
    logic [1:0]  rp, rl;
    logic [3:0]  rlen;
    logic [15:0] rpay;
    int          rn;

    rst   = 1'b1;
    serRx = 1'b1;
    for (int i = 0; i < 4; i++) lbModel[i] = 2'b00;
    #12;
    checkAllClear("reset");
    @(negedge clk);
    rst = 1'b0;

    // Port 2, line 11, three payload bits 1,0,1.
    addFrame(2'b10, 2'b11, 4'd3, 16'b101, 1'b0);
    addIdle(3);
    applyStimulus(100000);

    // Length 0 means 16 payload bits.
    addFrame(2'b01, 2'b00, 4'd0, 16'hFFFF, 1'b0);
    addIdle(2);
    applyStimulus(100000);

    // Back-to-back frames with no idle gap.
    addFrame(2'b00, 2'b01, 4'd1, 16'h0001, 1'b1);
    addFrame(2'b11, 2'b10, 4'd2, 16'b10, 1'b1);
    addIdle(2);
    applyStimulus(100000);

    // Payload 1,1,0,1 with good then bad parity.
    addFrame(2'b01, 2'b11, 4'd4, 16'b1011, 1'b1);
    addFrame(2'b01, 2'b11, 4'd4, 16'b1011, 1'b0);
    addIdle(2);
    applyStimulus(100000);

    addIdle(50);
    applyStimulus(100000);

    // Abort a frame mid-payload with a short asynchronous reset.
    addFrame(2'b10, 2'b01, 4'd8, 16'h00A5, 1'b0);
    applyStimulus(12);
    q.delete();
    #1;
    rst   = 1'b1;
    serRx = 1'b1;
    #1;
    checkAllClear("midReset");
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) lbModel[i] = 2'b00;
    addIdle(1);
    addFrame(2'b11, 2'b01, 4'd2, 16'b01, 1'b1);
    addIdle(2);
    applyStimulus(100000);

    for (int f = 0; f < 25; f++) begin
      addIdle($urandom_range(0, 2));
      rp   = 2'($urandom_range(0, 3));
      rl   = 2'($urandom_range(0, 3));
      rlen = 4'($urandom_range(0, 15));
      rpay = 16'($urandom);
      rn   = (rlen == 4'd0) ? 16 : int'(rlen);
      addFrame(rp, rl, rlen, rpay, payloadXor(rpay, rn) ^ ($urandom_range(0, 3) == 0));
    end
    addIdle(3);
    applyStimulus(100000);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/broadcast_framer.md
BROADCAST_FRAMER -- requirements
Module: broadcast_framer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port serRx, input, 1 bit: raw serial frame stream, idle level 1.
REQ-004 SHALL have port serIn, output, 1 bit: registered payload bit for the downstream broadcaster serIn.
REQ-005 SHALL have port PB, output, 4 bits [3:0]: one-hot port select; PB[p] high selects port p.
REQ-006 SHALL have ports LB0, LB1, LB2, LB3, output, 2 bits [0:1] each: per-port line select.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port frameErr, output, 1 bit: one-cycle parity-error pulse; see Configuration.

Function
REQ-009 SHALL sample serRx once per clock.
REQ-010 SHALL receive each frame as: start bit 0; 2 port bits; 2 line bits; 4 length bits; N payload bits; optional parity bit. All fields SHALL be MSB first.
REQ-011 SHALL implement states IDLE, PORT, LINE, LEN, DATA, and PAR. PAR SHALL exist only with the macro.
REQ-012 SHALL move IDLE->PORT when serRx=0 is sampled in IDLE; serRx=1 SHALL keep IDLE.
REQ-013 SHALL move PORT->LINE after 2 sampled bits, LINE->LEN after 2 bits, and LEN->DATA after 4 bits, using an internal bit counter.
REQ-014 SHALL set N = LEN field value, with LEN=0000 meaning N=16; the remaining-count register SHALL be 5 bits.
REQ-015 SHALL, on the edge that samples the last LEN bit, load LBp (p = port field) with the line field: first-received bit into LBp[0], second into LBp[1]; other LBx unchanged.
REQ-016 SHALL hold LB0..LB3 across frames until reloaded or reset.
REQ-017 SHALL, on each DATA edge, set serIn <= serRx and PB <= onehot(p), and decrement the count; latency serRx->serIn is 1 cycle.
REQ-018 SHALL leave DATA on the edge sampling payload bit N, going to IDLE (or PAR with the macro).
REQ-019 SHALL drive PB=0000 and serIn=0 on every edge not in DATA, so PB is nonzero for exactly N consecutive cycles aligned with serIn.
REQ-020 SHALL accept a start bit sampled on the cycle immediately after the last payload (or parity) bit, with no idle gap required.
REQ-021 SHALL hold busy registered: 1 from the edge after start-bit detection through the final frame bit's edge.

Reset
REQ-022 SHALL, while rst=1, immediately force state=IDLE, counters=0, serIn=0, PB=0000, LB0..LB3=00, busy=0, frameErr=0, regardless of clock.
REQ-023 SHALL, on rst assertion mid-frame, discard the frame; the first edge after deassertion SHALL be treated as IDLE.

Configuration
REQ-024 SHALL use macro BCAST_PARITY_EN. When defined: PAR state follows DATA; 1 bit is sampled; even parity over payload+parity bit is checked; on mismatch frameErr=1 for exactly the next cycle; PAR->IDLE always; PB=0000 and serIn=0 during PAR.
REQ-025 SHALL, when BCAST_PARITY_EN is undefined, omit the PAR state and parity logic; DATA->IDLE directly and frameErr is constant 0.

Verification
REQ-026 Bench SHALL drive: frame port=10, line=11, len=0011, payload 1,0,1 -> LB2=11 after the LEN edge; PB=0100 for exactly 3 cycles; serIn=1,0,1 each one cycle after sampling; then PB=0000 and busy=0.
REQ-027 Bench SHALL drive: len=0000, payload of 16 ones -> PB one-hot for exactly 16 cycles, then 0000.
REQ-028 Bench SHALL drive: back-to-back frames, port 00 line 01 len 0001 then immediately port 11 line 10 len 0010 -> PB 0001 (1 cycle), 0000 through the second header, then 1000 (2 cycles); LB0=01 retained, LB3=10.
REQ-029 Bench SHALL assert rst for 3 ns mid-DATA -> PB=0000, serIn=0, LBx=00, busy=0 without a clock edge; the next valid frame is received normally.
REQ-030 Bench SHALL hold serRx=1 for 50 cycles -> busy=0, PB=0000, no LB change.
REQ-031 Bench SHALL, with BCAST_PARITY_EN, send payload 1101 with parity 1 -> no frameErr, and with parity 0 -> frameErr high for exactly one cycle; without the macro, frameErr stays 0.
